// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer in front of a 16x8 synchronous RAM.
// Serialises single-word read/write commands and returns read data to the owning requester.
module ram_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter bit FAIR   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr_en,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_read_en,
   input  logic [DATA_W-1:0] ram_data_read,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

   state_t            state;
   logic              owner;
   logic              last_gnt;
   logic              cmd_we;
   logic              pick;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
   always_comb begin
      pick = 1'b0;
      if (r0_req && r1_req)
         pick = FAIR ? ~last_gnt : 1'b0;
      else if (r1_req)
         pick = 1'b1;
      sel_we    = pick ? r1_we    : r0_we;
      sel_addr  = pick ? r1_addr  : r0_addr;
      sel_wdata = pick ? r1_wdata : r0_wdata;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_gnt    <= 1'b1;
         cmd_we      <= 1'b0;
         r0_gnt      <= 1'b0;
         r1_gnt      <= 1'b0;
         r0_rvalid   <= 1'b0;
         r1_rvalid   <= 1'b0;
         r0_rdata    <= '0;
         r1_rdata    <= '0;
         ram_addr    <= '0;
         ram_data    <= '0;
         ram_wr_en   <= 1'b0;
         ram_read_en <= 1'b0;
         busy        <= 1'b0;
      end else begin
         // Pulses default low; only the state that owns them raises them for one cycle.
         r0_gnt      <= 1'b0;
         r1_gnt      <= 1'b0;
         r0_rvalid   <= 1'b0;
         r1_rvalid   <= 1'b0;
         ram_wr_en   <= 1'b0;
         ram_read_en <= 1'b0;
         case (state)
            IDLE: begin
               if (r0_req || r1_req) begin
                  owner       <= pick;
                  last_gnt    <= pick;
                  cmd_we      <= sel_we;
                  ram_addr    <= sel_addr;
                  ram_data    <= sel_wdata;
                  ram_wr_en   <= sel_we;
                  ram_read_en <= ~sel_we;
                  r0_gnt      <= ~pick;
                  r1_gnt      <= pick;
                  state       <= CMD;
                  busy        <= 1'b1;
               end
            end
            CMD: begin
               state <= cmd_we ? IDLE : RESP;
               busy  <= ~cmd_we;
            end
            RESP: begin
               // RAM output is valid now, one cycle after read_en was sampled.
               if (owner) begin
                  r1_rdata  <= ram_data_read;
                  r1_rvalid <= 1'b1;
               end else begin
                  r0_rdata  <= ram_data_read;
                  r0_rvalid <= 1'b1;
               end
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
